conv1x1_engine: RTL and testbench

Parametrised 1×1 convolution engine: P_OUT output-filter lanes each multiply a P_IN-channel signed int8 pixel beat by their own weight vector, reduce, and accumulate across successive channel-group beats until `last_channel`. It then adds a per-lane bias and presents P_OUT 32-bit results. It generalises the fixed 8×8 PE array with configurable lane/channel counts, a pipelined reduction, and a valid/ready output handshake with full-pipeline stall. It sits between the feature-map line buffer and the requantisation stage.

---
 rtl/conv1x1_pkg.sv | 26 ++
 rtl/conv1x1_engine_if.sv | 30 +++
 rtl/conv1x1_lane.sv | 88 ++++++++
 rtl/conv1x1_engine.sv | 62 ++++++
 tb/tb_conv1x1_engine.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv1x1_pkg.sv
// Shared defaults, element types and arithmetic helpers for the 1x1 convolution engine.
package conv1x1_pkg;

    localparam int unsigned DEF_P_OUT = 8;
    localparam int unsigned DEF_P_IN  = 8;
    localparam int unsigned DEF_ACC_W = 32;

    typedef logic signed [7:0]           pix_t;
    typedef logic signed [15:0]          prod_t;
    typedef logic signed [DEF_ACC_W-1:0] acc_t;

    // Signed 8x8 multiply; operands widened first so the full 16-bit product is kept.
    function automatic prod_t mul8(input pix_t a, input pix_t b);
        prod_t aw;
        prod_t bw;
        aw = prod_t'(a);
        bw = prod_t'(b);
        return aw * bw;
    endfunction

    // Extract channel c (signed int8) from a packed channel vector.
    function automatic pix_t chan_at(input logic [DEF_P_IN*8-1:0] vec, input int unsigned c);
        return pix_t'(vec[8*c +: 8]);
    endfunction

endpackage

// File: rtl/conv1x1_engine_if.sv
// Beat input, per-lane parameters and result handshake of the 1x1 convolution engine.
interface conv1x1_engine_if
    import conv1x1_pkg::*;
#(
    parameter int unsigned P_OUT = DEF_P_OUT,
    parameter int unsigned P_IN  = DEF_P_IN,
    parameter int unsigned ACC_W = DEF_ACC_W
) ();

    logic                  valid_in;
    logic                  in_ready;
    logic                  last_channel;
    logic [P_IN*8-1:0]     pixel;
    logic [P_IN*8-1:0]     weights [P_OUT];
    logic [ACC_W-1:0]      biases  [P_OUT];
    logic [ACC_W-1:0]      outs    [P_OUT];
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        output valid_in, last_channel, pixel, weights, biases, out_ready,
        input  in_ready, outs, out_valid
    );

    modport slave (
        input  valid_in, last_channel, pixel, weights, biases, out_ready,
        output in_ready, outs, out_valid
    );

endinterface

// File: rtl/conv1x1_lane.sv
// One output-filter lane: multipliers (S1), reduction (S2), accumulator and result register (S3).
// Build option: CONV1X1_RELU_EN clamps negative results to zero before they reach the output.
module conv1x1_lane
    import conv1x1_pkg::*;
#(
    parameter int unsigned P_IN  = DEF_P_IN,
    parameter int unsigned ACC_W = DEF_ACC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              s2_valid,
    input  logic              s2_last,
    input  logic [P_IN*8-1:0] pixel,
    input  logic [P_IN*8-1:0] weights,
    input  logic [ACC_W-1:0]  bias,
    output logic [ACC_W-1:0]  result
);

    prod_t                   prod_q [P_IN];
    logic signed [ACC_W-1:0] bias1_q, bias2_q;
    logic signed [ACC_W-1:0] sum_d, sum_q;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] total;
    logic signed [ACC_W-1:0] res_d, res_q;

    // S1: per-channel products; bias travels alongside so it lines up with the last beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned c = 0; c < P_IN; c++) begin
                prod_q[c] <= '0;
            end
            bias1_q <= '0;
        end else if (!stall) begin
            for (int unsigned c = 0; c < P_IN; c++) begin
                prod_q[c] <= mul8(pix_t'(pixel[8*c +: 8]), pix_t'(weights[8*c +: 8]));
            end
            bias1_q <= bias;
        end
    end

    // Reduction of the registered products, each sign-extended to the accumulator width.
    always_comb begin
        sum_d = '0;
        for (int unsigned c = 0; c < P_IN; c++) begin
            sum_d = sum_d + ACC_W'(prod_q[c]);
        end
    end

    // S2: registered beat sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q   <= '0;
            bias2_q <= '0;
        end else if (!stall) begin
            sum_q   <= sum_d;
            bias2_q <= bias1_q;
        end
    end

    // Completed-pixel value and optional clamp.
    always_comb begin
        total = acc_q + sum_q + bias2_q;
`ifdef CONV1X1_RELU_EN
        res_d = total[ACC_W-1] ? '0 : total;
`else
        res_d = total;
`endif
    end

    // S3: accumulate partial sums; the last beat loads the result and restarts the accumulator.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            res_q <= '0;
        end else if (!stall && s2_valid) begin
            if (s2_last) begin
                res_q <= res_d;
                acc_q <= '0;
            end else begin
                acc_q <= acc_q + sum_q;
            end
        end
    end

    assign result = res_q;

endmodule

// File: rtl/conv1x1_engine.sv
// 1x1 convolution engine: P_OUT lock-stepped lanes behind a shared valid pipeline and
// a valid/ready result handshake that stalls the whole pipeline.
// Build option: CONV1X1_RELU_EN (handled in conv1x1_lane) clamps negative results to zero.
module conv1x1_engine
    import conv1x1_pkg::*;
#(
    parameter int unsigned P_OUT = DEF_P_OUT,
    parameter int unsigned P_IN  = DEF_P_IN,
    parameter int unsigned ACC_W = DEF_ACC_W
) (
    input logic             clk,
    input logic             rst,
    conv1x1_engine_if.slave bus
);

    logic stall;
    logic accept;
    logic s1_valid_q, s1_last_q;
    logic s2_valid_q, s2_last_q;
    logic out_valid_q;

    // A held result that downstream has not taken freezes every stage.
    assign stall        = out_valid_q && !bus.out_ready;
    assign accept       = bus.valid_in && !stall;
    assign bus.in_ready = !stall;
    assign bus.out_valid = out_valid_q;

    // Shared valid/last pipeline; out_valid reloads whenever the output register may change.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_last_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (!stall) begin
            s1_valid_q  <= accept;
            s1_last_q   <= bus.last_channel;
            s2_valid_q  <= s1_valid_q;
            s2_last_q   <= s1_last_q;
            out_valid_q <= s2_valid_q && s2_last_q;
        end
    end

    for (genvar i = 0; i < P_OUT; i++) begin : g_lane
        conv1x1_lane #(
            .P_IN  (P_IN),
            .ACC_W (ACC_W)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .stall    (stall),
            .s2_valid (s2_valid_q),
            .s2_last  (s2_last_q),
            .pixel    (bus.pixel),
            .weights  (bus.weights[i]),
            .bias     (bus.biases[i]),
            .result   (bus.outs[i])
        );
    end

endmodule

// File: tb/tb_conv1x1_engine.sv
// Self-checking bench for conv1x1_engine: directed cases plus randomized streams with stalls,
// checked against an arithmetic reference model of the pixel accumulation.
module tb_conv1x1_engine;

    localparam int unsigned P_OUT = 8;
    localparam int unsigned P_IN  = 8;
    localparam int unsigned ACC_W = 32;

    typedef logic [P_OUT-1:0][ACC_W-1:0] vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    conv1x1_engine_if #(.P_OUT(P_OUT), .P_IN(P_IN), .ACC_W(ACC_W)) bus ();

    conv1x1_engine #(.P_OUT(P_OUT), .P_IN(P_IN), .ACC_W(ACC_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    vec_t exp_q[$];
    int   macc [P_OUT];
    bit   prev_stall = 1'b0;
    vec_t prev_outs;
    int   n_push = 0;
    int   n_pop  = 0;
    int   n_valid_seen = 0;
    int   first_v = -1;
    int   last_v  = -1;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic vec_t outs_now();
        vec_t v;
        for (int l = 0; l < P_OUT; l++) v[l] = bus.outs[l];
        return v;
    endfunction

    // Dot product of one beat, computed with plain signed integer arithmetic.
    function automatic int lane_sum(input logic [P_IN*8-1:0] px, input logic [P_IN*8-1:0] w);
        int s;
        int a;
        int b;
        s = 0;
        for (int c = 0; c < P_IN; c++) begin
            a = int'($signed(px[8*c +: 8]));
            b = int'($signed(w[8*c +: 8]));
            s = s + a * b;
        end
        return s;
    endfunction

    // Runs at the falling edge: observes the handshake that the next rising edge will perform.
    task automatic monitor();
        vec_t r;
        int   s;
        int   t;
        if (rst) begin
            for (int l = 0; l < P_OUT; l++) macc[l] = 0;
            exp_q.delete();
            prev_stall = 1'b0;
            return;
        end
        check("in_ready", {255'd0, bus.in_ready}, {255'd0, !(bus.out_valid && !bus.out_ready)});
        if (prev_stall) begin
            check("stall_outs", outs_now(), prev_outs);
            check("stall_valid", {255'd0, bus.out_valid}, 256'd1);
        end
        if (bus.out_valid) begin
            n_valid_seen++;
            if (first_v < 0) first_v = cyc;
            last_v = cyc;
        end
        if (bus.out_valid && bus.out_ready) begin
            n_tests++;
            assert (exp_q.size() != 0) else begin
                n_fail++;
                $error("FAIL out_extra: got %0h expected no result", outs_now());
            end
            if (exp_q.size() != 0) check("result", outs_now(), exp_q.pop_front());
            n_pop++;
        end
        if (bus.valid_in && bus.in_ready) begin
            r = '0;
            for (int l = 0; l < P_OUT; l++) begin
                s = lane_sum(bus.pixel, bus.weights[l]);
                if (bus.last_channel) begin
                    t = macc[l] + s + int'(bus.biases[l]);
`ifdef CONV1X1_RELU_EN
                    if (t < 0) t = 0;
`endif
                    r[l] = t;
                    macc[l] = 0;
                end else begin
                    macc[l] = macc[l] + s;
                end
            end
            if (bus.last_channel) begin
                exp_q.push_back(r);
                n_push++;
            end
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_outs  = outs_now();
    endtask

    task automatic cycle();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive_all(input logic [P_IN*8-1:0] px, input logic [P_IN*8-1:0] w,
                             input logic [ACC_W-1:0] b, input logic v, input logic last);
        bus.pixel = px;
        for (int l = 0; l < P_OUT; l++) begin
            bus.weights[l] = w;
            bus.biases[l]  = b;
        end
        bus.valid_in     = v;
        bus.last_channel = last;
    endtask

    task automatic wait_valid(input int max);
        int n;
        n = 0;
        while (!bus.out_valid && n < max) begin
            cycle();
            n++;
        end
        n_tests++;
        assert (bus.out_valid) else begin
            n_fail++;
            $error("FAIL timeout: out_valid got 0 expected 1");
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, {255'd0, bus.out_valid}, 256'd0);
        check({tag, "_ready"}, {255'd0, bus.in_ready}, 256'd1);
        check({tag, "_outs"}, outs_now(), 256'd0);
    endtask

    int   e;
    vec_t ev;

    initial begin
        drive_all('0, '0, '0, 1'b0, 1'b0);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        cycle();
        cycle();
        check_idle("reset");
        rst = 1'b0;
        cycle();

        // Single beat: 8 x (1*2) + 5 = 21, visible exactly three cycles after acceptance.
        drive_all({P_IN{8'd1}}, {P_IN{8'd2}}, 32'd5, 1'b1, 1'b1);
        cycle();
        bus.valid_in = 1'b0;
        cycle();
        check("lat_t2", {255'd0, bus.out_valid}, 256'd0);
        cycle();
        check("lat_t3", {255'd0, bus.out_valid}, 256'd1);
        check("single_21", outs_now(), {P_OUT{32'd21}});
        repeat (3) cycle();

        // Four beats of -3*4 over 8 channels, bias -100.
        for (int i = 0; i < 4; i++) begin
            drive_all({P_IN{8'hFD}}, {P_IN{8'd4}}, 32'hFFFF_FF9C, 1'b1, i == 3);
            cycle();
        end
        bus.valid_in = 1'b0;
        wait_valid(8);
`ifdef CONV1X1_RELU_EN
        e = 0;
`else
        e = -484;
`endif
        check("four_beat", outs_now(), {P_OUT{e}});
        repeat (3) cycle();

        // Extremes: (-128)*(-128)*8 = 131072.
        drive_all({P_IN{8'h80}}, {P_IN{8'h80}}, 32'd0, 1'b1, 1'b1);
        cycle();
        bus.valid_in = 1'b0;
        wait_valid(8);
        check("extreme", outs_now(), {P_OUT{32'd131072}});
        repeat (4) cycle();

        // Back-to-back single-beat pixels: one result per cycle, no bubbles.
        n_valid_seen = 0;
        first_v = -1;
        for (int l = 0; l < P_OUT; l++) bus.weights[l] = {$urandom, $urandom};
        for (int i = 0; i < 20; i++) begin
            bus.pixel = {$urandom, $urandom};
            for (int l = 0; l < P_OUT; l++) bus.biases[l] = $urandom;
            bus.valid_in     = 1'b1;
            bus.last_channel = 1'b1;
            cycle();
        end
        bus.valid_in = 1'b0;
        repeat (6) cycle();
        check("b2b_count", 256'(n_valid_seen), 256'd20);
        check("b2b_contig", 256'(last_v - first_v + 1), 256'd20);

        // Streaming with a 5-cycle downstream hold, then random valid/ready and multi-beat pixels.
        for (int l = 0; l < P_OUT; l++) bus.weights[l] = {$urandom, $urandom};
        for (int i = 0; i < 40; i++) begin
            bus.pixel = {$urandom, $urandom};
            for (int l = 0; l < P_OUT; l++) bus.biases[l] = $urandom;
            if (i < 13) begin
                bus.valid_in     = 1'b1;
                bus.last_channel = (i < 8) ? 1'b1 : 1'($urandom_range(0, 1));
                bus.out_ready    = !(i >= 8 && i < 13);
            end else begin
                bus.valid_in     = (i == 39) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
                bus.last_channel = (i == 39) ? 1'b1 : 1'($urandom_range(0, 2) == 0);
                bus.out_ready    = 1'($urandom_range(0, 2) != 0);
            end
            if (i >= 9 && i < 13) check("hold_in_ready", {255'd0, bus.in_ready}, 256'd0);
            cycle();
        end
        bus.valid_in  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (10) cycle();
        check("stream_drain", 256'(exp_q.size()), 256'd0);
        check("stream_count", 256'(n_pop), 256'(n_push));

        // Reset after two of four beats; the next pixel must carry no residue.
        for (int i = 0; i < 2; i++) begin
            drive_all({$urandom, $urandom}, {$urandom, $urandom}, $urandom, 1'b1, 1'b0);
            cycle();
        end
        bus.valid_in = 1'b0;
        rst = 1'b1;
        cycle();
        check_idle("midrst");
        rst = 1'b0;
        drive_all(64'd7, 64'd1, 32'd0, 1'b1, 1'b1);
        cycle();
        bus.valid_in = 1'b0;
        wait_valid(8);
        ev = {P_OUT{32'd7}};
        check("after_rst", outs_now(), ev);
        repeat (4) cycle();
        check("final_drain", 256'(exp_q.size()), 256'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
